// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep chunked ripple adder with valid/ready handshake.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
    $error("pipe_adder: illegal WIDTH/STAGES combination");
  end
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             v, c, pv, pc;
    logic [WIDTH-1:0] r, pa, pb, pr, nr;
    logic [C:0]       s;
    if (k == 0) begin : g_src
      assign pv = in_valid;
      assign pc = cin;
      assign pa = a;
      assign pb = b;
      assign pr = '0;
    end else begin : g_src
      assign pv = g_st[k-1].v;
      assign pc = g_st[k-1].c;
      assign pa = g_st[k-1].g_op.oa;
      assign pb = g_st[k-1].g_op.ob;
      assign pr = g_st[k-1].r;
    end
    assign s = {1'b0, pa[k*C +: C]} + {1'b0, pb[k*C +: C]} + (C+1)'(pc);
    always_comb begin
      nr = pr;
      nr[k*C +: C] = s[C-1:0];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        r <= '0;
      end else if (adv) begin
        v <= pv;
        c <= s[C];
        r <= nr;
      end
    // operands (including sign bits) travel alongside the partial result
    if (k < L) begin : g_op
      logic [WIDTH-1:0] oa, ob;
      always_ff @(posedge clk)
        if (adv) begin
          oa <= pa;
          ob <= pb;
        end
    end
  end
  assign out_valid = g_st[L].v;
  assign sum       = g_st[L].r;
  assign cout      = g_st[L].c;
`ifdef PIPE_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (adv) ovf <= (g_st[L].pa[WIDTH-1] == g_st[L].pb[WIDTH-1]) &&
                         (g_st[L].nr[WIDTH-1] != g_st[L].pa[WIDTH-1]);
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed checks of pipe_adder against an arithmetic model.
module tb_pipe_adder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, sum;
  logic        in_ready, out_valid, cout;
  logic [33:0] got;
  int          vecs = 0, errs = 0;
`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
  localparam logic [33:0] M = '1;
  assign got = {ovf, cout, sum};
`else
  localparam logic [33:0] M = 34'h1_FFFF_FFFF;
  assign got = {1'b0, cout, sum};
`endif
  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + 33'(ci);
    return {(x[31] == y[31]) && (t[31] != x[31]), t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom); out_ready = 1'($urandom);
      step();
      vecs++;
      if ({out_valid, cout, sum, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
        errs++;
        $display("FAIL reset: got valid=%b cout=%b sum=%h in_ready=%b, want 0 0 00000000 1", out_valid, cout, sum, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    step();
  endtask

  logic [31:0] da[5] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
  logic [31:0] db[5] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000, 32'h9ABCDEF0};
  logic        dc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic test_directed();
    logic [33:0] e;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = da[i]; b = db[i]; cin = dc[i]; out_ready = 1'b1;
      e = model(da[i], db[i], dc[i]);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (out_valid !== 1'b0) begin
          errs++;
          $display("FAIL latency[%0d] edge %0d: out_valid=%b, want 0", i, k, out_valid);
        end
        step();
      end
      vecs++;
      if (out_valid !== 1'b1 || (got & M) !== (e & M)) begin
        errs++;
        $display("FAIL directed[%0d]: valid=%b {ovf,cout,sum}=%h, want 1 %h", i, out_valid, got & M, e & M);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int ni = 1, no = 1;
    for (int cyc = 0; cyc < 40 && no <= 8; cyc++) begin
      in_valid = (ni <= 8); a = ni; b = ni; cin = 1'b0;
      out_ready = !(cyc >= 5 && cyc < 8);
      #1;
      if (!out_ready) begin
        vecs++;
        if (in_ready !== 1'b0) begin
          errs++;
          $display("FAIL stall in_ready cyc %0d: %b, want 0", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (sum !== 32'(2 * no) || cout !== 1'b0) begin
          errs++;
          $display("FAIL backpressure result %0d: sum=%0d cout=%b, want %0d 0", no, sum, cout, 2 * no);
        end
        no++;
      end
      if (in_valid && in_ready) ni++;
      step();
    end
    vecs++;
    if (no != 9) begin
      errs++;
      $display("FAIL backpressure count: %0d results, want 8", no - 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [33:0] q[$];
    logic [33:0] e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(3) != 0); a = $urandom; b = $urandom; cin = 1'($urandom);
      if ($urandom_range(7) == 0) begin a = 32'hFFFFFFFF; b = 32'h0; end
      out_ready = ($urandom_range(2) != 0);
      #1;
      vecs++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errs++;
        $display("FAIL random in_ready cyc %0d: %b, want %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        vecs++;
        e = (q.size() != 0) ? q.pop_front() : 34'h0;
        if ((got & M) !== (e & M)) begin
          errs++;
          $display("FAIL random result cyc %0d: %h, want %h", cyc, got & M, e & M);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) begin
      #1;
      if (out_valid) begin
        vecs++;
        e = q.pop_front();
        if ((got & M) !== (e & M)) begin
          errs++;
          $display("FAIL drain result: %h, want %h", got & M, e & M);
        end
      end
      step();
    end
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain timeout: %0d results missing, want 0", q.size());
    end
    step();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h1; cin = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++;
      $display("FAIL midflight precondition: out_valid=%b, want 1", out_valid);
    end
    rst_n = 1'b0;
    #2;
    vecs++;
    if ({out_valid, cout, sum} !== 34'h0) begin
      errs++;
      $display("FAIL async reset: valid=%b cout=%b sum=%h, want 0 0 0", out_valid, cout, sum);
    end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vecs++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL stale result after reset cyc %0d: out_valid=%b sum=%h, want 0", i, out_valid, sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    step();
    step();
    step();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter STAGES, default 4: number of pipeline register stages; each stage adds one chunk of C = WIDTH/STAGES bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, cin are valid this cycle.
REQ-006 in_ready  output  1  the block accepts operands this cycle.
REQ-007 a  input  WIDTH  addend A, unsigned (two's complement for the overflow flag).
REQ-008 b  input  WIDTH  addend B.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  sum, cout (and ovf) hold a completed result.
REQ-011 out_ready  input  1  the downstream accepts the result this cycle.
REQ-012 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag; this port exists only when PIPE_ADDER_OVF_EN is defined.

Function
REQ-015 Legal parameters: WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH mod STAGES == 0; any other combination is a compile-time error.
REQ-016 Input transfer occurs on a rising edge where in_valid and in_ready are both 1; output transfer occurs where out_valid and out_ready are both 1.
REQ-017 Advance condition: adv = !out_valid || out_ready; in_ready = adv, combinational, with no dependency on in_valid.
REQ-018 When adv = 1 every stage shifts forward by one; when adv = 0 all stage registers, including valid bits, hold their values.
REQ-019 Stage 1 registers sum bits [C-1:0] of a + b + cin, the carry out of that chunk, and the unconsumed upper operand chunks.
REQ-020 Stage k (k >= 2) adds operand chunk k-1 plus the stage k-1 registered carry, and registers the result chunk, its carry and the lower result bits passed along.
REQ-021 Each stage carries a valid bit; stage 1 loads in_valid when adv = 1; bubbles propagate and are not compressed.
REQ-022 Latency: an operand pair transferred on edge t appears on the outputs after edge t+STAGES-1 when there is no stall; each stall cycle adds exactly one cycle.
REQ-023 Throughput: one result per cycle while out_ready = 1.
REQ-024 sum, cout and ovf are driven directly from the last-stage registers, with no combinational path from the inputs.
REQ-025 Results leave in issue order; none is dropped or duplicated under any out_ready pattern.
REQ-026 When out_valid = 0, sum, cout and ovf hold their last register values and carry no meaning.
REQ-027 STAGES = 1 degenerates to a single registered WIDTH-bit adder with the same handshake.
REQ-028 Carry wraps out of bit WIDTH-1 into cout only; sum never exceeds WIDTH bits.

Reset
REQ-029 While rst_n = 0, all stage valid bits, out_valid, sum, cout and ovf are 0 immediately, without waiting for a clock edge.
REQ-030 Assertion of rst_n mid-operation discards every in-flight operation, with no partial result emitted; the first edge after release performs normal operation.

Configuration
REQ-031 Macro PIPE_ADDER_OVF_EN defined: port ovf exists, and ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), with the sign bits carried along the pipeline aligned to the result.
REQ-032 Macro PIPE_ADDER_OVF_EN undefined: the ovf port and its sign-bit pipeline registers are absent, and all other behaviour is identical.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-033 Reset: hold rst_n=0 with random inputs -> out_valid=0, sum=0x00000000, cout=0, in_ready=1.
REQ-034 Chunk carry: a=0x0000FFFF, b=0x00000001, cin=0, single transfer -> out_valid after 3 further edges, sum=0x00010000, cout=0.
REQ-035 Full ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-036 Backpressure: 8 back-to-back ops a=i, b=i (i=1..8), out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall; outputs are 2,4,...,16 in order with none lost.
REQ-037 Overflow, with PIPE_ADDER_OVF_EN: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0; and a=0x80000000, b=0x80000000 -> sum=0, ovf=1, cout=1.
REQ-038 Reset mid-flight: issue 3 ops, pulse rst_n low between edges -> out_valid=0 at once; none of the 3 results ever appears.
